d_r_message_slot_scheduler: RTL
===============================

Name: d_r_message_slot_scheduler

Overview:
Sequencer and occupancy tracker for the 5-slot decoder message buffer (slot select 0..4 in front of the buffer address).
- Tracks which slots are committed, which have finished ELP search, and which are free. Upstream is held off when the buffer is full.
- Owns the read port: it streams a decoded chunk out of the buffer (enable, address, valid, last) and then issues the completion pulse that frees the slot.
- Sits between the error-detection/ELP-search stages and the corrected-message output stage.

Parameters:
NumSlots, 5, number of chunk slots in the buffer (slot index wraps NumSlots-1 -> 0)
SlotSelWidth, 3, width of slot index and occupancy count
AddressWidth, 8, word address width within one slot
ChunkWords, 256, words read per chunk; 1 <= ChunkWords <= 2**AddressWidth

Ports:
i_clk  input  1  single clock for all logic
i_RESET  input  1  synchronous active-high reset
i_error_detection_stage_end  input  1  pulse: current write slot fully written, commit it
i_ELP_search_stage_end  input  1  pulse: oldest committed, undecoded slot is now decoded
i_out_grant  input  1  output stage may accept a new chunk
o_wr_slot  output  SlotSelWidth  slot currently being written
o_wr_ready  output  1  a free slot is available (occupancy < NumSlots)
o_rd_slot  output  SlotSelWidth  slot being or next to be read
o_rd_en  output  1  buffer read enable
o_rd_addr  output  AddressWidth  buffer word read address
o_dout_valid  output  1  buffer read data valid this cycle
o_dout_last  output  1  final word of the chunk valid this cycle
o_c_message_output_cmplt  output  1  one-cycle pulse: chunk fully output, slot released
o_occupancy  output  SlotSelWidth  committed slots, 0..NumSlots
o_error  output  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous, active-high): all outputs 0, both pointers 0, occupancy 0, decoded count 0, FSM to IDLE, o_error cleared. Buffer contents are untouched.
- Reset mid-stream: reset wins on that edge. Streaming stops immediately and no completion pulse is issued.
- Pointers: wr_ptr and rd_ptr each step +1 and wrap 4->0 (NumSlots-1 -> 0). o_wr_slot is wr_ptr; o_rd_slot is rd_ptr.
- Commit: i_error_detection_stage_end while occupancy < NumSlots -> wr_ptr advances and occupancy +1.
- Commit while full -> ignored (no pointer or count change) and o_error set.
- Decode: i_ELP_search_stage_end while decoded < occupancy -> decoded +1. Otherwise ignored and o_error set.
- Release happens in the cycle o_c_message_output_cmplt is high: rd_ptr advances, occupancy -1, decoded -1, all at the end of that cycle.
- Simultaneous events in one cycle:
  - commit + release -> occupancy unchanged, both pointers advance.
  - decode + release -> decoded unchanged.
  - Full with commit + release in the same cycle -> commit accepted.
- o_wr_ready = (occupancy != NumSlots), taken from registered state.
- FSM states:
  - IDLE: if decoded > 0 and i_out_grant, go to READ with address 0.
  - READ: o_rd_en = 1 and o_rd_addr increments each cycle. When o_rd_addr == ChunkWords-1, go to DRAIN.
  - DRAIN: one cycle covering the buffer's 1-cycle read latency; then return to IDLE.
- Datapath timing:
  - o_dout_valid is o_rd_en delayed one cycle.
  - o_dout_last is (READ and address == ChunkWords-1) delayed one cycle, so it is high in the DRAIN cycle.
  - o_c_message_output_cmplt is high in the DRAIN cycle, coincident with o_dout_last.
- Latency: grant sampled in IDLE at cycle t -> o_rd_en from t+1 -> first valid at t+2 -> completion pulse at t+1+ChunkWords.
- Back-to-back chunks have at least one IDLE cycle between them.
- No mid-chunk backpressure: i_out_grant is sampled only in IDLE.
- Width rules: all counters are unsigned; the address counter never exceeds ChunkWords-1.

Decomposition:
- Shared package holds:
  - constants NUM_SLOTS = 5 and SLOT_SEL_WIDTH = 3;
  - FSM state encoding IDLE = 0, READ = 1, DRAIN = 2, 2 bits.
- One sub-module, d_r_slot_ring_counter: a wrap-at-NumSlots-1 pointer with an advance input. It is instantiated twice, once for wr_ptr and once for rd_ptr.

Test Plan:
- Reset, then 5 commits with no decode -> o_occupancy = 5, o_wr_ready = 0, o_wr_slot = 0 (wrapped). A 6th commit -> occupancy stays 5 and o_error = 1.
- 1 commit, 1 decode, grant held high, ChunkWords = 4 -> o_rd_addr 0,1,2,3 on consecutive cycles; o_dout_valid for 4 cycles; o_dout_last and cmplt together on the 4th valid; then o_rd_slot = 1 and o_occupancy = 0.
- Decode pulse with decoded == occupancy -> decoded count unchanged, o_error = 1, no read starts.
- Occupancy 5 with a chunk in DRAIN, commit in the same cycle as cmplt -> commit accepted, occupancy stays 5, wr_ptr and rd_ptr both advance.
- 7 full commit/decode/output cycles -> o_rd_slot sequence 0,1,2,3,4,0,1 and every completion pulse exactly 1 cycle wide.
- Reset asserted mid-READ at address 2 -> next cycle o_rd_en = 0, all outputs 0, FSM IDLE, no cmplt pulse.

Source files
------------

// File: rtl/d_r_message_slot_scheduler_pkg.sv
// Shared constants and FSM encoding for the decoder message-buffer slot scheduler.
package d_r_message_slot_scheduler_pkg;

    localparam int unsigned NUM_SLOTS      = 5;
    localparam int unsigned SLOT_SEL_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/d_r_slot_ring_counter.sv
// Slot pointer that steps by one on advance and wraps NumSlots-1 -> 0.
module d_r_slot_ring_counter
    import d_r_message_slot_scheduler_pkg::*;
#(
    parameter int unsigned NumSlots = NUM_SLOTS,
    parameter int unsigned Width    = SLOT_SEL_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance_i,
    output logic [Width-1:0] ptr_o
);

    logic [Width-1:0] ptr_q;
    logic [Width-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (ptr_q == Width'(NumSlots - 1)) ? '0 : ptr_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/d_r_message_slot_scheduler.sv
// Occupancy tracker and read sequencer for the 5-slot decoder message buffer;
// streams one decoded chunk per grant and releases its slot with a completion pulse.
module d_r_message_slot_scheduler
    import d_r_message_slot_scheduler_pkg::*;
#(
    parameter int unsigned NumSlots     = NUM_SLOTS,
    parameter int unsigned SlotSelWidth = SLOT_SEL_WIDTH,
    parameter int unsigned AddressWidth = 8,
    parameter int unsigned ChunkWords   = 256
) (
    input  logic                    i_clk,
    input  logic                    i_RESET,
    input  logic                    i_error_detection_stage_end,
    input  logic                    i_ELP_search_stage_end,
    input  logic                    i_out_grant,
    output logic [SlotSelWidth-1:0] o_wr_slot,
    output logic                    o_wr_ready,
    output logic [SlotSelWidth-1:0] o_rd_slot,
    output logic                    o_rd_en,
    output logic [AddressWidth-1:0] o_rd_addr,
    output logic                    o_dout_valid,
    output logic                    o_dout_last,
    output logic                    o_c_message_output_cmplt,
    output logic [SlotSelWidth-1:0] o_occupancy,
    output logic                    o_error
);

    localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(ChunkWords - 1);
    localparam logic [SlotSelWidth-1:0] FULL_OCC  = SlotSelWidth'(NumSlots);

    sched_state_e state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [SlotSelWidth-1:0] occ_q, occ_d;
    logic [SlotSelWidth-1:0] dec_q, dec_d;
    logic rd_en_q, rd_en_d;
    logic valid_q, last_q, cmplt_q, cmplt_d;
    logic wr_ready_q, error_q, error_d;
    logic commit_ok, decode_ok, release_w;

    // A release frees a slot in the same cycle, so a commit while full is legal then.
    assign release_w = cmplt_q;
    assign commit_ok = i_error_detection_stage_end && ((occ_q != FULL_OCC) || release_w);
    assign decode_ok = i_ELP_search_stage_end && (dec_q < occ_q);

    always_comb begin
        occ_d   = occ_q + SlotSelWidth'(commit_ok) - SlotSelWidth'(release_w);
        dec_d   = dec_q + SlotSelWidth'(decode_ok) - SlotSelWidth'(release_w);
        error_d = error_q
                | (i_error_detection_stage_end && !commit_ok)
                | (i_ELP_search_stage_end && !decode_ok);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cmplt_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((dec_q != '0) && i_out_grant) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    cmplt_d = 1'b1;
                end else begin
                    addr_d = addr_q + AddressWidth'(1);
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        rd_en_d = (state_d == ST_READ);
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            occ_q      <= '0;
            dec_q      <= '0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            cmplt_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            occ_q      <= occ_d;
            dec_q      <= dec_d;
            rd_en_q    <= rd_en_d;
            valid_q    <= rd_en_q;
            last_q     <= (state_q == ST_READ) && (addr_q == LAST_ADDR);
            cmplt_q    <= cmplt_d;
            wr_ready_q <= (occ_d != FULL_OCC);
            error_q    <= error_d;
        end
    end

    d_r_slot_ring_counter #(
        .NumSlots(NumSlots),
        .Width   (SlotSelWidth)
    ) u_wr_ptr (
        .clk_i    (i_clk),
        .rst_i    (i_RESET),
        .advance_i(commit_ok),
        .ptr_o    (o_wr_slot)
    );

    d_r_slot_ring_counter #(
        .NumSlots(NumSlots),
        .Width   (SlotSelWidth)
    ) u_rd_ptr (
        .clk_i    (i_clk),
        .rst_i    (i_RESET),
        .advance_i(release_w),
        .ptr_o    (o_rd_slot)
    );

    assign o_wr_ready               = wr_ready_q;
    assign o_rd_en                  = rd_en_q;
    assign o_rd_addr                = addr_q;
    assign o_dout_valid             = valid_q;
    assign o_dout_last              = last_q;
    assign o_c_message_output_cmplt = cmplt_q;
    assign o_occupancy              = occ_q;
    assign o_error                  = error_q;

endmodule
